// File: rtl/ser_sel_pkg.sv
// ser_sel_pkg: shared state encodings and constants for the serialising selector controller
package ser_sel_pkg;
    localparam int DIV_W_DEF = 8;
    typedef enum logic {ST_IDLE = 1'b0, ST_SHIFT = 1'b1} state_t;
    localparam logic [2:0] SEL_FIRST_LSB = 3'd0;
    localparam logic [2:0] SEL_FIRST_MSB = 3'd7;
endpackage

// File: rtl/bit_tick_gen.sv
// bit_tick_gen: per-bit cycle counter, pulses tick on the last cycle of each bit period
module bit_tick_gen import ser_sel_pkg::*; #(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] div_q,
    output logic             tick
);
    logic [DIV_W-1:0] count;
    assign tick = (count == div_q);
    // count restarts at div_q, so all-ones div never overflows
    always_ff @(posedge clk) begin
        if (rst || clr) count <= '0;
        else count <= tick ? '0 : count + 1'b1;
    end
endmodule

// File: rtl/sel_8_1.sv
// sel_8_1: 8:1 selector with active-low enable, output low when disabled
module sel_8_1 (
    input  logic [7:0] D,
    input  logic [2:0] sel,
    input  logic       n_EN,
    output logic       Y
);
    assign Y = n_EN ? 1'b0 : D[sel];
endmodule

// File: rtl/ser_sel_ctrl.sv
// ser_sel_ctrl: accepts a word and steps an 8:1 selector through its bits, one bit per div+1 cycles
module ser_sel_ctrl import ser_sel_pkg::*; #(
    parameter int DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic [DIV_W-1:0] div,
    input  logic             msb_first,
    output logic [7:0]       D,
    output logic [2:0]       sel,
    output logic             n_EN,
    output logic             busy,
    output logic             done
);
    state_t           state, state_n;
    logic [DIV_W-1:0] div_q, div_n;
    logic             dir_q, dir_n;
    logic [7:0]       d_n;
    logic [2:0]       sel_n, sel_last;
    logic             n_en_n, done_n, tick;

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state == ST_SHIFT);
    assign sel_last = dir_q ? SEL_FIRST_LSB : SEL_FIRST_MSB;

    bit_tick_gen #(.DIV_W(DIV_W)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (in_ready),
        .div_q(div_q),
        .tick (tick)
    );

    // next-state: accept in IDLE, step sel on each tick, finish after the last index
    always_comb begin
        state_n = state;
        d_n     = D;
        div_n   = div_q;
        dir_n   = dir_q;
        sel_n   = sel;
        n_en_n  = n_EN;
        done_n  = 1'b0;
        if (state == ST_IDLE && in_valid) begin
            state_n = ST_SHIFT;
            d_n     = in_data;
            div_n   = div;
            dir_n   = msb_first;
            sel_n   = msb_first ? SEL_FIRST_MSB : SEL_FIRST_LSB;
            n_en_n  = 1'b0;
        end else if (state == ST_SHIFT && tick) begin
            if (sel == sel_last) begin
                state_n = ST_IDLE;
                sel_n   = 3'd0;
                n_en_n  = 1'b1;
                done_n  = 1'b1;
            end else begin
                sel_n = dir_q ? sel - 3'd1 : sel + 3'd1;
            end
        end
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            D     <= '0;
            div_q <= '0;
            dir_q <= 1'b0;
            sel   <= 3'd0;
            n_EN  <= 1'b1;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            D     <= d_n;
            div_q <= div_n;
            dir_q <= dir_n;
            sel   <= sel_n;
            n_EN  <= n_en_n;
            done  <= done_n;
        end
    end
endmodule

// File: tb/tb_ser_sel_ctrl.sv
// tb_ser_sel_ctrl: scoreboard bench for ser_sel_ctrl driving a downstream sel_8_1
module tb_ser_sel_ctrl;
    logic       clk = 1'b0, rst = 1'b1, in_valid = 1'b0, msb_first = 1'b0;
    logic [7:0] in_data = '0, div = '0;
    logic       in_ready, n_EN, busy, done, Y;
    logic [7:0] D;
    logic [2:0] sel;

    typedef struct {bit is_done; logic [2:0] s; logic y; logic [7:0] w;} ent_t;
    ent_t q[$];
    int total = 0, bad = 0;
    int left = 0, cyc = 0, acc_count = 0, last_acc = 0, prev_acc = 0;
    int done_cyc = 0, run = 0, last_gap = 0;
    bit mon_en = 0;

    ser_sel_ctrl #(.DIV_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .div(div), .msb_first(msb_first),
        .D(D), .sel(sel), .n_EN(n_EN), .busy(busy), .done(done)
    );
    sel_8_1 u_sel (.D(D), .sel(sel), .n_EN(n_EN), .Y(Y));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // reference model: a frame is 8 bits in the chosen order, each repeated div+1 times, then a done
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            q.delete();
            left = 0;
        end else if (left == 0) begin
            if (in_valid) begin
                for (int i = 0; i < 8; i++) begin
                    int idx;
                    idx = msb_first ? 7 - i : i;
                    for (int r = 0; r <= int'(div); r++)
                        q.push_back('{0, 3'(idx), in_data[idx], in_data});
                end
                q.push_back('{1, 3'd0, 1'b0, 8'd0});
                left = 8 * (int'(div) + 1);
                acc_count++;
                prev_acc = last_acc;
                last_acc = cyc;
            end
        end else begin
            left--;
        end
    end

    // monitor: compare every presented bit and done pulse against the scoreboard
    always @(negedge clk) begin
        if (mon_en) begin
            check("in_ready", in_ready, left == 0);
            check("busy", busy, left != 0);
            check("n_EN", n_EN, left == 0);
            if (done || !n_EN) begin
                if (q.size() == 0) begin
                    check("unexpected_output", {done, n_EN}, 2'b01);
                end else begin
                    ent_t e;
                    e = q.pop_front();
                    check("done_order", done, e.is_done);
                    if (!done) begin
                        check("sel", sel, e.s);
                        check("Y", Y, e.y);
                        check("D", D, e.w);
                    end else begin
                        done_cyc = cyc;
                    end
                end
            end
            if (n_EN) run++;
            else begin
                if (run > 0) last_gap = run;
                run = 0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int max);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((q.size() != 0 || left != 0) && n < max);
        check("idle_timeout", (q.size() != 0 || left != 0), 0);
    endtask

    task automatic wait_acc(input int target, input int max);
        int n;
        n = 0;
        while (acc_count < target && n < max) begin
            step();
            n++;
        end
        check("accept_timeout", acc_count >= target, 1);
    endtask

    task automatic send(input logic [7:0] data, input logic [7:0] dv, input logic msb);
        in_valid = 1; in_data = data; div = dv; msb_first = msb;
        step();
        in_valid = 0;
    endtask

    initial begin
        int base;
        // 1: reset with random inputs
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'($urandom); in_data = 8'($urandom); div = 8'($urandom); msb_first = 1'($urandom);
            step();
        end
        check("rst_n_EN", n_EN, 1); check("rst_sel", sel, 0); check("rst_D", D, 0);
        check("rst_busy", busy, 0); check("rst_done", done, 0); check("rst_in_ready", in_ready, 1);
        in_valid = 0;
        rst = 0;
        mon_en = 1;
        step();
        // 2: LSB-first AA, div 0
        send(8'hAA, 8'd0, 0);
        wait_idle(50);
        check("t2_len", done_cyc - last_acc, 8);
        // 3: MSB-first AA, div 3
        send(8'hAA, 8'd3, 1);
        wait_idle(100);
        check("t3_len", done_cyc - last_acc, 32);
        // 4: back-to-back with held valid
        base = acc_count;
        in_valid = 1; in_data = 8'hF0; div = 0; msb_first = 0;
        step();
        in_data = 8'h0F;
        wait_acc(base + 2, 50);
        in_valid = 0;
        check("t4_spacing", last_acc - prev_acc, 9);
        wait_idle(50);
        check("t4_gap", last_gap, 1);
        // 5: busy rejection, mid-frame input changes ignored
        base = acc_count;
        send(8'h3C, 8'd1, 0);
        repeat (3) step();
        in_valid = 1; in_data = 8'h55; div = 8'd5; msb_first = 1;
        step();
        check("t5_in_ready", in_ready, 0);
        check("t5_D", D, 8'h3C);
        wait_acc(base + 2, 50);
        in_valid = 0;
        check("t5_len", last_acc - prev_acc, 17);
        wait_idle(100);
        // 6: reset mid-frame at sel=4
        send(8'($urandom), 8'd0, 0);
        repeat (4) step();
        check("t6_sel_before", sel, 4);
        rst = 1;
        step();
        rst = 0;
        check("t6_n_EN", n_EN, 1); check("t6_sel", sel, 0); check("t6_D", D, 0); check("t6_done", done, 0);
        step();
        check("t6_no_done", done, 0);
        send(8'h81, 8'd0, 0);
        wait_idle(50);
        // random traffic with occasional long divisors and resets
        for (int i = 0; i < 6000; i++) begin
            in_valid  = ($urandom % 3) == 0;
            in_data   = 8'($urandom);
            div       = ($urandom % 25 == 0) ? 8'd255 : 8'($urandom_range(0, 3));
            msb_first = 1'($urandom);
            rst       = ($urandom % 700) == 0;
            step();
        end
        in_valid = 0; rst = 0;
        wait_idle(3000);
        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ser_sel_ctrl.md
Name: ser_sel_ctrl

Overview:
Sequencing controller that sits directly upstream of the 8:1 selector (sel_8_1) and serialises an 8-bit word through it. It accepts a word over a valid/ready handshake and holds it on D. It then steps sel through all eight positions, holding each for a programmable number of cycles, with n_EN asserted low for the frame. The selector output Y becomes the serial bit stream; a done pulse marks frame end.

Parameters:
DIV_W, 8, width of the per-bit cycle divider input and internal tick counter.

Ports:
clk  input  1  single system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  source has a word on in_data
in_ready  output  1  controller can accept a word (high only in IDLE)
in_data  input  8  word to serialise
div  input  DIV_W  cycles per bit minus 1 (0 = one cycle per bit)
msb_first  input  1  1: sel runs 7..0; 0: sel runs 0..7
D  output  8  latched word, drives sel_8_1 D
sel  output  3  current bit index, drives sel_8_1 sel
n_EN  output  1  active-low enable to sel_8_1, low only while a frame is in progress
busy  output  1  high while in SHIFT
done  output  1  one-cycle pulse on the first cycle after the last bit

Behaviour:
- One clock clk; reset rst is synchronous and active-high.
- Reset values: D=0, sel=0, n_EN=1, busy=0, done=0; state=IDLE, so in_ready=1 on the first post-reset cycle.
- States: IDLE and SHIFT. in_ready = (state==IDLE), combinational from state. busy = (state==SHIFT).
- Accept: when in_valid && in_ready at a clock edge:
  - Latch D<=in_data, div_q<=div, dir_q<=msb_first.
  - sel<=(msb_first ? 7 : 0), n_EN<=0, tick<=0, state<=SHIFT.
  - The first bit is therefore presented the cycle after the accept.
- SHIFT: each sel value is held for div_q+1 cycles.
  - When tick==div_q: tick<=0 and sel steps (-1 if dir_q, else +1).
  - Otherwise tick<=tick+1.
- Last bit: when tick==div_q and sel is the final index (0 if dir_q, else 7):
  - state<=IDLE, n_EN<=1, sel<=0, done<=1 for exactly one cycle.
  - D holds its value until the next accept.
- Frame length: 8*(div_q+1) cycles with n_EN=0.
- Back-to-back frames: in_ready is high in the done cycle, so a held in_valid is accepted there. This leaves exactly one cycle with n_EN=1 between frames.
- in_valid while busy: ignored. The source must hold in_data until in_ready.
- div or msb_first changing mid-frame: ignored, because the latched copies govern the frame.
- sel never wraps within a frame. tick is DIV_W bits wide; div = all-ones gives 2^DIV_W cycles per bit with no overflow, since tick resets at div_q.
- rst mid-frame: the frame is aborted and all outputs return to reset values on the next edge. No done pulse is produced.
- done and in_ready are never high while n_EN=0.

Decomposition:
- Shared package ser_sel_pkg holds:
  - state encodings ST_IDLE=1'b0, ST_SHIFT=1'b1;
  - SEL_FIRST_LSB=3'd0 and SEL_FIRST_MSB=3'd7;
  - the DIV_W default.
- One natural sub-module, bit_tick_gen. It is the DIV_W-bit tick counter with a clear input; it takes div_q and outputs a tick pulse when count==div_q. The FSM, sel stepping and handshake stay in ser_sel_ctrl.
- The bench instantiates sel_8_1 downstream and checks Y.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with random inputs -> n_EN=1, sel=0, D=0, busy=0, done=0, in_ready=1.
2. LSB-first, in_data=8'hAA, div=0, one-cycle in_valid -> sel=0..7 on cycles 1..8 after accept; Y=0,1,0,1,0,1,0,1; done=1 on cycle 9 with n_EN=1.
3. MSB-first, in_data=8'hAA, div=3 -> sel=7,6,...,0, each held 4 cycles; Y=1,0,1,0,1,0,1,0 in 4-cycle runs; done exactly 33 cycles after accept.
4. Back-to-back: in_valid held, 8'hF0 then 8'h0F, div=0, LSB-first -> second accept in the done cycle; Y=0000_1111 then 1111_0000; exactly one n_EN=1 cycle between frames.
5. Busy rejection: during a div=1 frame of 8'h3C, drive in_valid with 8'h55 and change div to 5 and msb_first to 1 mid-frame -> in_ready=0, D stays 8'h3C, frame lasts 16 cycles in LSB order; 8'h55 is accepted in the done cycle.
6. Reset mid-frame: assert rst for 1 cycle while sel=4 -> next edge gives n_EN=1, sel=0, D=0, no done pulse; a subsequent 8'h81 frame with div=0 completes normally (Y=1,0,0,0,0,0,0,1).
